pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard, forwarding and flush controller for the 5-stage 16-bit pipeline (IF/ID/EX/MEM/WB).
- Replaces the ad-hoc forwarding and hazard-detection pair with one block.
- Tracks destination/valid info for EX, MEM and WB internally, so the datapath feeds it only ID-stage decode and the EX branch outcome.
- Adds multi-cycle divide stalls, branch flush and implicit R15 (remainder) destination tracking.

---
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle between the pipeline datapath and the hazard
// controller. The datapath (master) supplies ID-stage decode plus the EX
// branch outcome; the controller (slave) returns stall, flush, hold and
// forwarding selects, and the optional performance counters.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_div;
    logic                  ex_branch_taken;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  idex_hold;
    logic                  exmem_bubble;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_regwrite, id_memread, id_div, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_flush, idex_hold,
               exmem_bubble, fwd_a, fwd_b, stall_cycles, flush_events
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_regwrite, id_memread, id_div, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_flush, idex_hold,
               exmem_bubble, fwd_a, fwd_b, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and flush controller for the 5-stage
// 16-bit pipeline. Shadows destination info for EX, MEM and WB so the
// datapath only supplies ID decode and the EX branch outcome. Handles
// load-use stalls, multi-cycle divides (which also write R15 with the
// remainder) and taken-branch flushes.
// Optional build macro: PIPE_PERF_CNT_EN adds saturating stall/flush counters;
// without it stall_cycles and flush_events are tied to zero.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int DIV_LAT    = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [REG_ADDR_W-1:0] R15 = {REG_ADDR_W{1'b1}};
    localparam int                    DCNT_W = $clog2(DIV_LAT + 1);
    localparam logic [DCNT_W-1:0]     DIV_LOAD = DCNT_W'(DIV_LAT - 1);
    localparam logic [DCNT_W-1:0]     DCNT_ONE = DCNT_W'(1);

    typedef enum logic {RUN, DIV_WAIT} state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  div;
    } dst_t;

    typedef struct packed {
        dst_t                  d;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
        logic                  memread;
    } ex_t;

    state_t            state_q, state_d;
    logic [DCNT_W-1:0] cnt_q, cnt_d;
    ex_t               ex_q, ex_next;
    dst_t              mem_q, wb_q;
    logic              mem_memread_q;

    logic       load_use, div_start;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_bubble;
    logic [1:0] fwd_a, fwd_b;

    // A stage entry produces src if it writes rd==src, or it is a divide and src is R15
    function automatic logic hits(input dst_t e, input logic [REG_ADDR_W-1:0] src);
        return e.valid && e.we && ((e.rd == src) || (e.div && (src == R15)));
    endfunction

    // Hazard conditions seen by the controller this cycle
    always_comb begin
        div_start = ex_q.d.valid && ex_q.d.div;
        load_use  = ex_q.d.valid && ex_q.memread && ex_q.d.we && bus.id_valid &&
                    ((bus.id_uses_rs && (bus.id_rs == ex_q.d.rd)) ||
                     (bus.id_uses_rt && (bus.id_rt == ex_q.d.rd)));
    end

    // ID decode captured into EX; a flushed slot becomes an all-zero bubble
    always_comb begin
        ex_next = '0;
        if (bus.id_valid && !idex_flush) begin
            ex_next.d.valid = 1'b1;
            ex_next.d.rd    = bus.id_rd;
            ex_next.d.we    = bus.id_regwrite;
            ex_next.d.div   = bus.id_div;
            ex_next.rs      = bus.id_rs;
            ex_next.rt      = bus.id_rt;
            ex_next.uses_rs = bus.id_uses_rs;
            ex_next.uses_rt = bus.id_uses_rt;
            ex_next.memread = bus.id_memread;
        end
    end

    // Shadow of the EX/MEM/WB destination info, advanced in step with the pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q          <= '0;
            mem_q         <= '0;
            mem_memread_q <= 1'b0;
            wb_q          <= '0;
        end else begin
            if (!idex_hold) begin
                ex_q <= ex_next;
            end
            if (idex_hold || exmem_bubble) begin
                mem_q         <= '0;
                mem_memread_q <= 1'b0;
            end else begin
                mem_q         <= ex_q.d;
                mem_memread_q <= ex_q.memread;
            end
            wb_q <= mem_q;
        end
    end

    // FSM state and divide countdown register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a divide reaching EX starts the countdown; count 1 is its last EX cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (div_start) begin
                    state_d = DIV_WAIT;
                    cnt_d   = DIV_LOAD;
                end
            end
            DIV_WAIT: begin
                cnt_d = cnt_q - DCNT_ONE;
                if (cnt_q == DCNT_ONE) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Pipeline control: divide hold, then taken branch, then load-use stall
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        case (state_q)
            RUN: begin
                if (div_start) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                end else if (bus.ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            DIV_WAIT: begin
                if (cnt_q > DCNT_ONE) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                end
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
    end

    // Operand forwarding for the instruction in EX; EX/MEM wins over MEM/WB, loads in MEM never forward
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_q.d.valid && ex_q.uses_rs) begin
            if (hits(mem_q, ex_q.rs) && !mem_memread_q) begin
                fwd_a = 2'b10;
            end else if (hits(wb_q, ex_q.rs)) begin
                fwd_a = 2'b01;
            end
        end
        if (ex_q.d.valid && ex_q.uses_rt) begin
            if (hits(mem_q, ex_q.rt) && !mem_memread_q) begin
                fwd_b = 2'b10;
            end else if (hits(wb_q, ex_q.rt)) begin
                fwd_b = 2'b01;
            end
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.idex_hold    = idex_hold;
    assign bus.exmem_bubble = exmem_bubble;
    assign bus.fwd_a        = fwd_a;
    assign bus.fwd_b        = fwd_b;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Saturating counts of stalled-PC cycles and IF/ID flush cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (ifid_flush && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_events = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: acts as the datapath for pipe_hazard_ctrl, feeding ID
// decode step by step and scoring the control outputs and counters.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_PERF_CNT_EN
    localparam int TB_CNT_W = 4;
    localparam bit PERF_EN  = 1'b1;
`else
    localparam int TB_CNT_W = 16;
    localparam bit PERF_EN  = 1'b0;
`endif

    // control vector: pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_bubble, fwd_a, fwd_b
    localparam logic [9:0] NOM  = 10'b1100000000;
    localparam logic [9:0] LU   = 10'b0001000000;
    localparam logic [9:0] HLD  = 10'b0000110000;
    localparam logic [9:0] BRF  = 10'b1111000000;
    localparam logic [9:0] FA10 = 10'b0000001000;
    localparam logic [9:0] FA01 = 10'b0000000100;
    localparam logic [9:0] FB10 = 10'b0000000010;

    typedef struct packed {
        logic       valid;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urs;
        logic       urt;
        logic [3:0] rd;
        logic       we;
        logic       mr;
        logic       dv;
    } instr_t;

    typedef struct {
        string      name;
        instr_t     id;
        logic       br;
        logic [9:0] ctl;
    } step_t;

    typedef struct {
        string      name;
        logic [9:0] ctl;
    } exp_t;

    localparam instr_t NOP = '0;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [TB_CNT_W-1:0] exp_stall = '0;
    logic [TB_CNT_W-1:0] exp_flush = '0;
    logic [9:0] ctl_obs;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(TB_CNT_W)) bus ();

    pipe_hazard_ctrl #(.REG_ADDR_W(4), .DIV_LAT(8), .CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign ctl_obs = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
                      bus.idex_hold, bus.exmem_bubble, bus.fwd_a, bus.fwd_b};

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic instr_t ins(input logic [3:0] rs, input logic [3:0] rt, input logic urs,
                                   input logic urt, input logic [3:0] rd, input logic we,
                                   input logic mr, input logic dv);
        instr_t i;
        i = '{valid: 1'b1, rs: rs, rt: rt, urs: urs, urt: urt, rd: rd, we: we, mr: mr, dv: dv};
        return i;
    endfunction

    function automatic step_t st(input string name, input instr_t id, input logic br,
                                 input logic [9:0] ctl);
        step_t s;
        s.name = name;
        s.id   = id;
        s.br   = br;
        s.ctl  = ctl;
        return s;
    endfunction

    // Reference counter model advanced once per scored cycle
    task automatic model_step(input logic [9:0] c);
        if (PERF_EN && !c[9] && (exp_stall != {TB_CNT_W{1'b1}})) exp_stall = exp_stall + 1'b1;
        if (PERF_EN && c[7] && (exp_flush != {TB_CNT_W{1'b1}})) exp_flush = exp_flush + 1'b1;
    endtask

    // Drive one ID-stage cycle and queue the expected controller response
    task automatic apply_stimulus(input step_t s);
        bus.id_valid        = s.id.valid;
        bus.id_rs           = s.id.rs;
        bus.id_rt           = s.id.rt;
        bus.id_uses_rs      = s.id.urs;
        bus.id_uses_rt      = s.id.urt;
        bus.id_rd           = s.id.rd;
        bus.id_regwrite     = s.id.we;
        bus.id_memread      = s.id.mr;
        bus.id_div          = s.id.dv;
        bus.ex_branch_taken = s.br;
        sb.push_back('{s.name, s.ctl});
    endtask

    task automatic test_reset();
        exp_t e;
        apply_stimulus(st("reset", NOP, 1'b0, NOM));
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if (ctl_obs !== e.ctl) begin
            n_bad++;
            $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
        end
        n_cmp++;
        if ({bus.stall_cycles, bus.flush_events} !== {TB_CNT_W*2{1'b0}}) begin
            n_bad++;
            $display("[TB] FAIL %s counters: got %0d/%0d want 0/0", e.name, bus.stall_cycles, bus.flush_events);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_load_use();
        step_t steps[$];
        exp_t  e;
        repeat (3) steps.push_back(st("lu_bubble", NOP, 1'b0, NOM));
        steps.push_back(st("lu_ld", ins(4'd1, 4'd0, 1, 0, 4'd3, 1, 1, 0), 1'b0, NOM));
        steps.push_back(st("lu_stall", ins(4'd3, 4'd2, 1, 1, 4'd4, 1, 0, 0), 1'b0, LU));
        steps.push_back(st("lu_reissue", ins(4'd3, 4'd2, 1, 1, 4'd4, 1, 0, 0), 1'b0, NOM));
        steps.push_back(st("lu_fwd_wb", NOP, 1'b0, NOM | FA01));
        foreach (steps[i]) begin
            apply_stimulus(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (ctl_obs !== e.ctl) begin
                n_bad++;
                $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
            end
            n_cmp++;
            if ({bus.stall_cycles, bus.flush_events} !== {exp_stall, exp_flush}) begin
                n_bad++;
                $display("[TB] FAIL %s counters: got %0d/%0d want %0d/%0d", e.name,
                         bus.stall_cycles, bus.flush_events, exp_stall, exp_flush);
            end
            model_step(e.ctl);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_fwd_priority();
        step_t steps[$];
        exp_t  e;
        repeat (3) steps.push_back(st("pri_bubble", NOP, 1'b0, NOM));
        steps.push_back(st("pri_add", ins(4'd2, 4'd3, 1, 1, 4'd1, 1, 0, 0), 1'b0, NOM));
        steps.push_back(st("pri_sub", ins(4'd4, 4'd5, 1, 1, 4'd1, 1, 0, 0), 1'b0, NOM));
        steps.push_back(st("pri_or", ins(4'd1, 4'd1, 1, 1, 4'd5, 1, 0, 0), 1'b0, NOM));
        steps.push_back(st("pri_exmem", NOP, 1'b0, NOM | FA10 | FB10));
        foreach (steps[i]) begin
            apply_stimulus(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (ctl_obs !== e.ctl) begin
                n_bad++;
                $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
            end
            n_cmp++;
            if ({bus.stall_cycles, bus.flush_events} !== {exp_stall, exp_flush}) begin
                n_bad++;
                $display("[TB] FAIL %s counters: got %0d/%0d want %0d/%0d", e.name,
                         bus.stall_cycles, bus.flush_events, exp_stall, exp_flush);
            end
            model_step(e.ctl);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_divide();
        step_t  steps[$];
        exp_t   e;
        instr_t add15;
        add15 = ins(4'd15, 4'd0, 1, 1, 4'd7, 1, 0, 0);
        repeat (3) steps.push_back(st("div_bubble", NOP, 1'b0, NOM));
        steps.push_back(st("div_issue", ins(4'd2, 4'd6, 1, 1, 4'd2, 1, 0, 1), 1'b0, NOM));
        for (int k = 0; k < 7; k++)
            steps.push_back(st($sformatf("div_hold%0d", k), add15, (k == 3), HLD));
        steps.push_back(st("div_final", add15, 1'b0, NOM));
        steps.push_back(st("div_r15_fwd", NOP, 1'b0, NOM | FA10));
        foreach (steps[i]) begin
            apply_stimulus(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (ctl_obs !== e.ctl) begin
                n_bad++;
                $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
            end
            n_cmp++;
            if ({bus.stall_cycles, bus.flush_events} !== {exp_stall, exp_flush}) begin
                n_bad++;
                $display("[TB] FAIL %s counters: got %0d/%0d want %0d/%0d", e.name,
                         bus.stall_cycles, bus.flush_events, exp_stall, exp_flush);
            end
            model_step(e.ctl);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        step_t steps[$];
        exp_t  e;
        repeat (3) steps.push_back(st("br_bubble", NOP, 1'b0, NOM));
        steps.push_back(st("br_ld", ins(4'd1, 4'd0, 1, 0, 4'd3, 1, 1, 0), 1'b0, NOM));
        steps.push_back(st("br_flush", ins(4'd3, 4'd2, 1, 1, 4'd4, 1, 0, 0), 1'b1, BRF));
        steps.push_back(st("br_nostall", NOP, 1'b0, NOM));
        foreach (steps[i]) begin
            apply_stimulus(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (ctl_obs !== e.ctl) begin
                n_bad++;
                $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
            end
            n_cmp++;
            if ({bus.stall_cycles, bus.flush_events} !== {exp_stall, exp_flush}) begin
                n_bad++;
                $display("[TB] FAIL %s counters: got %0d/%0d want %0d/%0d", e.name,
                         bus.stall_cycles, bus.flush_events, exp_stall, exp_flush);
            end
            model_step(e.ctl);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use_div();
        step_t  steps[$];
        exp_t   e;
        instr_t dv;
        dv = ins(4'd3, 4'd6, 1, 1, 4'd4, 1, 0, 1);
        repeat (3) steps.push_back(st("ludiv_bubble", NOP, 1'b0, NOM));
        steps.push_back(st("ludiv_ld", ins(4'd1, 4'd0, 1, 0, 4'd3, 1, 1, 0), 1'b0, NOM));
        steps.push_back(st("ludiv_stall", dv, 1'b0, LU));
        steps.push_back(st("ludiv_enter", dv, 1'b0, NOM));
        steps.push_back(st("ludiv_hold0", NOP, 1'b0, HLD | FA01));
        for (int k = 1; k < 7; k++)
            steps.push_back(st($sformatf("ludiv_hold%0d", k), NOP, 1'b0, HLD));
        steps.push_back(st("ludiv_final", NOP, 1'b0, NOM));
        foreach (steps[i]) begin
            apply_stimulus(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (ctl_obs !== e.ctl) begin
                n_bad++;
                $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
            end
            n_cmp++;
            if ({bus.stall_cycles, bus.flush_events} !== {exp_stall, exp_flush}) begin
                n_bad++;
                $display("[TB] FAIL %s counters: got %0d/%0d want %0d/%0d", e.name,
                         bus.stall_cycles, bus.flush_events, exp_stall, exp_flush);
            end
            model_step(e.ctl);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_div();
        step_t steps[$];
        step_t post[$];
        exp_t  e;
        repeat (3) steps.push_back(st("rst_bubble", NOP, 1'b0, NOM));
        steps.push_back(st("rst_div", ins(4'd2, 4'd6, 1, 1, 4'd2, 1, 0, 1), 1'b0, NOM));
        steps.push_back(st("rst_hold0", NOP, 1'b0, HLD));
        steps.push_back(st("rst_hold1", NOP, 1'b0, HLD));
        foreach (steps[i]) begin
            apply_stimulus(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (ctl_obs !== e.ctl) begin
                n_bad++;
                $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
            end
            model_step(e.ctl);
            @(posedge clk);
            #1;
        end
        apply_stimulus(st("rst_abort", NOP, 1'b0, NOM));
        #1 reset = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if (ctl_obs !== e.ctl) begin
            n_bad++;
            $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
        end
        n_cmp++;
        if ({bus.stall_cycles, bus.flush_events} !== {exp_stall, exp_flush}) begin
            n_bad++;
            $display("[TB] FAIL %s counters: got %0d/%0d want %0d/%0d", e.name,
                     bus.stall_cycles, bus.flush_events, exp_stall, exp_flush);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        post.push_back(st("rst_issue", ins(4'd2, 4'd3, 1, 1, 4'd1, 1, 0, 0), 1'b0, NOM));
        post.push_back(st("rst_nohold", NOP, 1'b0, NOM));
        foreach (post[i]) begin
            apply_stimulus(post[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (ctl_obs !== e.ctl) begin
                n_bad++;
                $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
            end
            n_cmp++;
            if ({bus.stall_cycles, bus.flush_events} !== {exp_stall, exp_flush}) begin
                n_bad++;
                $display("[TB] FAIL %s counters: got %0d/%0d want %0d/%0d", e.name,
                         bus.stall_cycles, bus.flush_events, exp_stall, exp_flush);
            end
            model_step(e.ctl);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_perf_counters();
        step_t  steps[$];
        exp_t   e;
        instr_t ld, add;
        ld  = ins(4'd1, 4'd0, 1, 0, 4'd3, 1, 1, 0);
        add = ins(4'd3, 4'd2, 1, 1, 4'd4, 1, 0, 0);
        reset = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
        @(negedge clk);
        n_cmp++;
        if ({bus.stall_cycles, bus.flush_events} !== {exp_stall, exp_flush}) begin
            n_bad++;
            $display("[TB] FAIL perf_clear counters: got %0d/%0d want 0/0",
                     bus.stall_cycles, bus.flush_events);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            steps.push_back(st("perf_div", ins(4'd8, 4'd9, 1, 1, 4'd10, 1, 0, 1), 1'b0, NOM));
            repeat (7) steps.push_back(st("perf_div_hold", NOP, 1'b0, HLD));
            steps.push_back(st("perf_div_final", NOP, 1'b0, NOM));
        end
        steps.push_back(st("perf_gap", NOP, 1'b0, NOM));
        steps.push_back(st("perf_ld1", ld, 1'b0, NOM));
        steps.push_back(st("perf_stall1", add, 1'b0, LU));
        steps.push_back(st("perf_add1", add, 1'b0, NOM));
        steps.push_back(st("perf_ld2", ld, 1'b0, NOM | FA01));
        steps.push_back(st("perf_stall2", add, 1'b0, LU));
        steps.push_back(st("perf_add2", add, 1'b0, NOM));
        steps.push_back(st("perf_branch", NOP, 1'b1, BRF | FA01));
        steps.push_back(st("perf_tail0", NOP, 1'b0, NOM));
        steps.push_back(st("perf_tail1", NOP, 1'b0, NOM));
        foreach (steps[i]) begin
            apply_stimulus(steps[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (ctl_obs !== e.ctl) begin
                n_bad++;
                $display("[TB] FAIL %s ctl: got %b want %b", e.name, ctl_obs, e.ctl);
            end
            n_cmp++;
            if ({bus.stall_cycles, bus.flush_events} !== {exp_stall, exp_flush}) begin
                n_bad++;
                $display("[TB] FAIL %s counters: got %0d/%0d want %0d/%0d", e.name,
                         bus.stall_cycles, bus.flush_events, exp_stall, exp_flush);
            end
            model_step(e.ctl);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_rs = '0;
        bus.id_rt = '0;
        bus.id_uses_rs = 1'b0;
        bus.id_uses_rt = 1'b0;
        bus.id_rd = '0;
        bus.id_regwrite = 1'b0;
        bus.id_memread = 1'b0;
        bus.id_div = 1'b0;
        bus.ex_branch_taken = 1'b0;
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_divide();
        test_branch();
        test_load_use_div();
        test_reset_mid_div();
        test_perf_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
